// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics ASIC register bus controller:
// FSM state encoding and the ASIC register map.
package gfx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_ERR
  } gfx_state_t;

  localparam int PADDLE_1_X   = 0;
  localparam int PADDLE_1_Y   = 1;
  localparam int PADDLE_2_X   = 2;
  localparam int PADDLE_2_Y   = 3;
  localparam int BALL_X       = 4;
  localparam int BALL_Y       = 5;
  localparam int BALL_Z       = 6;
  localparam int P1_SCORE     = 7;
  localparam int P2_SCORE     = 8;
  localparam int GAME_STATE   = 9;
  localparam int GFX_NUM_REGS = 10;

endpackage

// File: rtl/gfx_bus_arbiter_if.sv
// Requester-side handshake plus ASIC databus signals of the register bus controller.
interface gfx_bus_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic [1:0]          req;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic                frame_hold;
  logic [1:0]          ack;
  logic                err;
  logic [DATA_W-1:0]   rdata;
  logic                chipselect;
  logic                read;
  logic [ADDR_W-1:0]   data_address;
  logic [DATA_W-1:0]   bus_wdata;
  logic                bus_oe;
  logic [DATA_W-1:0]   bus_rdata;

  // The controller is the bus master towards the ASIC.
  modport master (
    input  req, req_we, req_addr, req_wdata, frame_hold, bus_rdata,
    output ack, err, rdata, chipselect, read, data_address, bus_wdata, bus_oe
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, frame_hold, bus_rdata,
    input  ack, err, rdata, chipselect, read, data_address, bus_wdata, bus_oe
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/gfx_bus_arbiter.sv
// Master-side controller for the graphics ASIC register databus: arbitrates two
// requesters and sequences single-word writes and registered reads.
module gfx_bus_arbiter
  import gfx_pkg::*;
#(
  parameter int NUM_REGS = GFX_NUM_REGS,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  gfx_bus_arbiter_if.master  bus
);

  gfx_state_t        state_q;
  gfx_state_t        state_d;
  logic              last_grant_q;
  logic              grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              grant_valid;
  logic              grant_idx;
  logic              take;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [1:0]        ack_bit;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
  endfunction

  rr_arb2 u_arb (
    .req         (bus.req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign take      = (state_q == ST_IDLE) && !bus.frame_hold && grant_valid;
  assign win_we    = grant_idx ? bus.req_we[1] : bus.req_we[0];
  assign win_addr  = grant_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                               : bus.req_addr[ADDR_W-1:0];
  assign win_wdata = grant_idx ? bus.req_wdata[2*DATA_W-1:DATA_W]
                               : bus.req_wdata[DATA_W-1:0];

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        last_grant_q <= grant_idx;
        grant_q      <= grant_idx;
      end
    end
  end

  // Request payload is only observed through state-gated outputs, so it needs no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q  <= win_addr;
      wdata_q <= win_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (!addr_ok(win_addr)) state_d = ST_ERR;
          else if (win_we)        state_d = ST_WR;
          else                    state_d = ST_RD_REQ;
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD_REQ:  state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign ack_bit = grant_q ? 2'b10 : 2'b01;

  always_comb begin
    bus.ack          = 2'b00;
    bus.err          = 1'b0;
    bus.rdata        = '0;
    bus.chipselect   = 1'b0;
    bus.read         = 1'b0;
    bus.data_address = '0;
    bus.bus_wdata    = '0;
    bus.bus_oe       = 1'b0;
    case (state_q)
      ST_WR: begin
        bus.chipselect   = 1'b1;
        bus.bus_oe       = 1'b1;
        bus.data_address = addr_q;
        bus.bus_wdata    = wdata_q;
        bus.ack          = ack_bit;
      end
      ST_RD_REQ: begin
        bus.chipselect   = 1'b1;
        bus.read         = 1'b1;
        bus.data_address = addr_q;
      end
      // ASIC drives its registered word this cycle and releases the bus at the closing edge.
      ST_RD_DATA: begin
        bus.rdata = bus.bus_rdata;
        bus.ack   = ack_bit;
      end
      ST_ERR: begin
        bus.err = 1'b1;
        bus.ack = ack_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gfx_bus_arbiter.sv
// Bench for gfx_bus_arbiter with a small ASIC register-file model on the databus.
module tb_gfx_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  gfx_bus_arbiter_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  gfx_bus_arbiter #(.NUM_REGS(10), .ADDR_W(4), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ASIC model: writes captured at the WR closing edge, read word registered for one cycle.
  logic [15:0] asic_regs [0:15];
  logic [15:0] asic_q;
  logic        asic_drive;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) asic_regs[i] <= 16'h1000 + 16'(i);
      asic_regs[7] <= 16'd5;
      asic_drive   <= 1'b0;
      asic_q       <= 16'h0;
    end else begin
      if (bus.chipselect && !bus.read && bus.bus_oe)
        asic_regs[bus.data_address] <= bus.bus_wdata;
      asic_drive <= bus.chipselect && bus.read;
      if (bus.chipselect && bus.read) asic_q <= asic_regs[bus.data_address];
    end
  end

  assign bus.bus_rdata = asic_drive ? asic_q : 16'h0;

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    @(negedge clk);
    bus.req[v.port]                = 1'b1;
    bus.req_we[v.port]             = v.we;
    bus.req_addr[v.port*4 +: 4]    = v.addr;
    bus.req_wdata[v.port*16 +: 16] = v.wdata;
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      if (c < v.lat) begin
        check("rdreq_ctl", {bus.chipselect, bus.read, bus.bus_oe, bus.ack}, 64'b11000);
        check("rdreq_addr", 64'(bus.data_address), 64'(v.addr));
      end else begin
        check("ack", 64'(bus.ack), (v.port == 1) ? 64'd2 : 64'd1);
        check("err", 64'(bus.err), 64'(v.err));
        check("rdata", 64'(bus.rdata), 64'(v.rdata));
        if (v.err)
          check("err_nobus", {bus.chipselect, bus.read, bus.bus_oe}, 64'b000);
        else if (v.we) begin
          check("wr_ctl", {bus.chipselect, bus.read, bus.bus_oe}, 64'b101);
          check("wr_addr", 64'(bus.data_address), 64'(v.addr));
          check("wr_data", 64'(bus.bus_wdata), 64'(v.wdata));
        end else
          check("rddata_ctl", {bus.chipselect, bus.bus_oe}, 64'b00);
        bus.req[v.port] = 1'b0;
      end
    end
    @(negedge clk);
    check("idle_after", {bus.ack, bus.chipselect, bus.err, bus.rdata}, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.req        = 2'b00;
    bus.frame_hold = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.ack, bus.err, bus.rdata, bus.chipselect, bus.read,
                            bus.data_address, bus.bus_wdata, bus.bus_oe}, 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nacks;
    int          cyc;
    int          viol;
    logic [15:0] wd0;
    logic [15:0] wd1;

    rst            = 1'b1;
    bus.req        = 2'b00;
    bus.req_we     = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.frame_hold = 1'b0;

    vecs[0] = '{port: 0, we: 1'b1, addr: 4'd4,  wdata: 16'd300,  lat: 1, err: 1'b0, rdata: 16'h0};
    vecs[1] = '{port: 1, we: 1'b0, addr: 4'd7,  wdata: 16'h0,    lat: 2, err: 1'b0, rdata: 16'd5};
    vecs[2] = '{port: 1, we: 1'b1, addr: 4'd9,  wdata: 16'hBEEF, lat: 1, err: 1'b0, rdata: 16'h0};
    vecs[3] = '{port: 0, we: 1'b0, addr: 4'd9,  wdata: 16'h0,    lat: 2, err: 1'b0, rdata: 16'hBEEF};
    vecs[4] = '{port: 0, we: 1'b1, addr: 4'd12, wdata: 16'h1234, lat: 1, err: 1'b1, rdata: 16'h0};
    vecs[5] = '{port: 1, we: 1'b0, addr: 4'd10, wdata: 16'h0,    lat: 1, err: 1'b1, rdata: 16'h0};
    vecs[6] = '{port: 0, we: 1'b0, addr: 4'd3,  wdata: 16'h0,    lat: 2, err: 1'b0, rdata: 16'h1003};
    vecs[7] = '{port: 1, we: 1'b0, addr: 4'd4,  wdata: 16'h0,    lat: 2, err: 1'b0, rdata: 16'd300};

    do_reset();
    for (int i = 0; i < 8; i++) do_txn(vecs[i]);
    check("asic_ball_x", 64'(asic_regs[4]), 64'd300);
    check("asic_reg9", 64'(asic_regs[9]), 64'hBEEF);

    // Both ports writing continuously: strict alternation starting with port 0.
    do_reset();
    wd0 = 16'hA000;
    wd1 = 16'hB000;
    bus.req_we              = 2'b11;
    bus.req_addr            = {4'd2, 4'd0};
    bus.req_wdata           = {wd1, wd0};
    bus.req                 = 2'b11;
    nacks = 0;
    cyc   = 0;
    while (nacks < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != 2'b00) begin
        check("rr_order", 64'(bus.ack), (nacks % 2 == 0) ? 64'd1 : 64'd2);
        if (nacks % 2 == 0) begin
          check("rr_wdata0", 64'(bus.bus_wdata), 64'(wd0));
          wd0 = wd0 + 16'd1;
          bus.req_wdata[15:0] = wd0;
        end else begin
          check("rr_wdata1", 64'(bus.bus_wdata), 64'(wd1));
          wd1 = wd1 + 16'd1;
          bus.req_wdata[31:16] = wd1;
        end
        nacks++;
      end
    end
    check("rr_count", 64'(nacks), 64'd8);
    bus.req = 2'b00;
    @(negedge clk);
    check("rr_asic0", 64'(asic_regs[0]), 64'hA003);
    check("rr_asic2", 64'(asic_regs[2]), 64'hB003);

    // frame_hold blocks a pending request; release grants in the same IDLE cycle.
    bus.frame_hold         = 1'b1;
    bus.req_we[0]          = 1'b1;
    bus.req_addr[3:0]      = 4'd1;
    bus.req_wdata[15:0]    = 16'h0055;
    bus.req[0]             = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.chipselect || bus.ack != 2'b00) viol++;
    end
    check("hold_quiet", 64'(viol), 64'd0);
    bus.frame_hold = 1'b0;
    @(negedge clk);
    check("hold_release_wr", {bus.ack, bus.chipselect, bus.bus_oe, bus.data_address, bus.bus_wdata},
          {2'b01, 1'b1, 1'b1, 4'd1, 16'h0055});
    bus.req[0] = 1'b0;
    @(negedge clk);

    // frame_hold rising during RD_REQ lets the read finish.
    bus.req_we[0] = 1'b0;
    bus.req[0]    = 1'b1;
    @(negedge clk);
    check("hold_rdreq", {bus.chipselect, bus.read}, 64'b11);
    bus.frame_hold = 1'b1;
    @(negedge clk);
    check("hold_rd_ack", {bus.ack, bus.rdata}, {2'b01, 16'h0055});
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("hold_rd_idle", {bus.ack, bus.chipselect}, 64'h0);
    bus.frame_hold = 1'b0;

    // Reset during RD_REQ aborts without ack; the following tie goes to port 0.
    bus.req_we[1]     = 1'b0;
    bus.req_addr[7:4] = 4'd7;
    bus.req[1]        = 1'b1;
    @(negedge clk);
    check("abort_rdreq", {bus.chipselect, bus.read}, 64'b11);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {bus.ack, bus.err, bus.rdata, bus.chipselect, bus.read,
                            bus.data_address, bus.bus_wdata, bus.bus_oe}, 64'h0);
    rst                 = 1'b0;
    bus.req_we          = 2'b11;
    bus.req_addr        = {4'd5, 4'd6};
    bus.req_wdata       = {16'h0777, 16'h0666};
    bus.req             = 2'b11;
    @(negedge clk);
    check("tie_after_reset", {bus.ack, bus.data_address, bus.bus_wdata}, {2'b01, 4'd6, 16'h0666});
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("tie_gap", 64'(bus.ack), 64'd0);
    @(negedge clk);
    check("tie_second", {bus.ack, bus.data_address, bus.bus_wdata}, {2'b10, 4'd5, 16'h0777});
    bus.req[1] = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gfx_bus_arbiter.md
Name: gfx_bus_arbiter

Overview:
Master-side controller for the graphics ASIC register databus (chipselect/read/data_address/16-bit databus).
- Arbitrates two requesters with round-robin priority: requester 0 is the game-logic CPU port, requester 1 is the paddle-input/debug port.
- Sequences single-word write and read transactions with the ASIC's one-cycle registered read turnaround.
- Blocks new grants while frame_hold is high, so a batch of position updates is never split across the ASIC's end-of-frame buffer latch.

Parameters:
- NUM_REGS, 10, count of valid ASIC register addresses (0..NUM_REGS-1); addresses >= NUM_REGS are rejected.
- ADDR_W, 4, width of the register address.
- DATA_W, 16, width of the data word.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- req  input  2  per-requester request; held high until that requester's ack.
- req_we  input  2  per-requester op: 1 = write, 0 = read.
- req_addr  input  2*ADDR_W  per-requester register address; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  2*DATA_W  per-requester write data.
- frame_hold  input  1  1 = grant nothing new; an in-flight transaction still completes.
- ack  output  2  one-cycle completion pulse per requester.
- err  output  1  valid with ack: the address was out of range.
- rdata  output  DATA_W  read data, valid with a read ack.
- chipselect  output  1  to ASIC chipselect.
- read  output  1  to ASIC read.
- data_address  output  ADDR_W  to ASIC data_address.
- bus_wdata  output  DATA_W  write value for the databus; the top-level tristate drives it when bus_oe=1.
- bus_oe  output  1  databus drive enable.
- bus_rdata  input  DATA_W  databus as sampled from the pad.

Behaviour:
- Reset:
  - State IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All outputs 0: ack, err, rdata, chipselect, read, data_address, bus_wdata, bus_oe.
  - A reset in any state aborts the transaction with no ack; outputs are 0 in the next cycle.
- FSM states: IDLE, WR, RD_REQ, RD_DATA, ERR. Outputs are decoded from the registered state, grant index and latched request; they are glitch-free.
- IDLE:
  - If frame_hold=0 and any req is high, select the winner. A single requester wins outright; if both request, the requester != last_grant wins.
  - On the next edge: latch the winner's we/addr/wdata, set last_grant = winner, and go to
    - ERR if addr >= NUM_REGS,
    - else WR if we=1,
    - else RD_REQ.
  - If frame_hold=1, stay in IDLE regardless of req.
- WR (1 cycle):
  - chipselect=1, read=0, bus_oe=1, data_address and bus_wdata from the latch, ack[g]=1.
  - The ASIC captures at the closing edge. Next state IDLE.
- RD_REQ (1 cycle):
  - chipselect=1, read=1, bus_oe=0, data_address from the latch. Next state RD_DATA.
- RD_DATA (1 cycle):
  - chipselect=0, bus_oe=0; the ASIC is driving its registered word.
  - rdata = bus_rdata (combinational pass), ack[g]=1. Next state IDLE.
  - The ASIC releases the bus at this closing edge, so the IDLE cycle that follows is the turnaround. No bus drive occurs before the next WR.
- ERR (1 cycle): no bus activity, ack[g]=1, err=1, rdata=0. Next state IDLE.
- Timing:
  - Write: req sampled at edge k, ack during cycle k+1. One write per 2 cycles per port.
  - Read: req sampled at edge k, ack and rdata valid during cycle k+2. One read per 3 cycles.
- Outside an ack cycle, rdata=0 and err=0.
- Requester rules:
  - A requester changes req_we/addr/wdata only after its ack.
  - Inputs are latched at grant, so later changes do not affect the in-flight transaction.
  - A requester dropping req before its ack after grant is a protocol violation. The transaction still completes and still acks.
- frame_hold:
  - Rising during WR or a read completes that transaction normally.
  - Falling: arbitration resumes in the same IDLE cycle.
- Simultaneous ack and new req from the same port: the new req is seen at the next IDLE. With both ports active, round-robin alternates strictly (0,1,0,1).
- At most one ack bit is high per cycle. chipselect is never high in two consecutive cycles except the RD_REQ that follows a grant.

Decomposition:
- Shared package gfx_pkg holds:
  - the state enum;
  - the ASIC register index constants (PADDLE_1_X=0, PADDLE_1_Y=1, PADDLE_2_X=2, PADDLE_2_Y=3, BALL_X=4, BALL_Y=5, BALL_Z=6, P1_SCORE=7, P2_SCORE=8, GAME_STATE=9);
  - GFX_NUM_REGS=10.
- One natural sub-module: rr_arb2.
  - Inputs req[1:0] and last_grant; outputs grant_valid and grant_idx.
  - Purely combinational, reused by other shared-bus controllers.

Test Plan:
- Reset, then req[0]=1, we=1, addr=4, wdata=16'd300 -> next cycle: chipselect=1, read=0, bus_oe=1, data_address=4, bus_wdata=300, ack=2'b01; ASIC model BALL_X=300.
- ASIC reg 7 preloaded to 16'd5; req[1] read addr=7 -> chipselect=1/read=1 for exactly one cycle, then ack=2'b10 with rdata=5; bus_oe stays 0 throughout.
- Both ports continuously write (addr 0 and 2) for 8 transactions -> grants alternate 0,1,0,1,...; requester 0 first after reset; no two ack bits ever high together.
- frame_hold=1 with req[0] pending for 20 cycles -> chipselect stays 0, no ack; drop frame_hold -> WR occurs the next cycle. Raising frame_hold during RD_REQ -> the read still completes with ack.
- req[0] addr=12 -> one cycle later ack[0]=1, err=1, rdata=0, chipselect never asserted.
- Assert rst during RD_REQ -> no ack; next cycle all outputs 0, state IDLE; a subsequent tie grants requester 0.
